core_datapath: RTL

Register-file and bus datapath for one matrix-multiply core; the execution end of the control unit's command interface. Each cycle it decodes the control unit's source select (`read_en`), destination strobes (`write_en`), increment/clear strobes (`inc_en`, `rst_en`) and `alu_op`. From these it drives the shared internal bus, updates its registers, runs the ALU, and addresses the instruction and data memories. It returns `ins` (IR) and `z` (ALU result) to the control unit.

---
 rtl/core_datapath.sv | 134 +++++++++++++
 1 files changed

// File: rtl/core_datapath.sv
// Register file, internal bus and ALU for one matrix-multiply core.
// Define CORE_DATAPATH_MUL_EN to build the multiplier; otherwise alu_op=3 yields 0.
module core_datapath #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [7:0]        inc_en,
    input  logic [7:0]        rst_en,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] ins,
    output logic [DATA_W-1:0] z,
    output logic [DATA_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    output logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we
);
    // Register slots are numbered by their bus source code; slot 0 is a constant zero.
    localparam int NREG = 16;
    localparam logic [3:0] R_PC  = 4'd1;
    localparam logic [3:0] R_DAR = 4'd2;
    localparam logic [3:0] R_IR  = 4'd3;
    localparam logic [3:0] R_AC  = 4'd4;

    typedef logic [DATA_W-1:0] word_t;

    word_t regs_q [NREG];
    word_t regs_d [NREG];
    word_t aluq_q, aluq_d;
    word_t bus;
    logic  unused_bits;

    function automatic logic [3:0] wr_reg(input logic [3:0] b);
        case (b)
            4'd0:    return 4'd1;
            4'd1:    return 4'd2;
            4'd2:    return 4'd3;
            4'd3:    return 4'd4;
            4'd4:    return 4'd5;
            4'd5:    return 4'd6;
            4'd6:    return 4'd10;
            4'd7:    return 4'd11;
            4'd8:    return 4'd12;
            4'd9:    return 4'd13;
            4'd10:   return 4'd14;
            4'd11:   return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] inc_reg(input logic [2:0] b);
        case (b)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd7;
            3'd4:    return 4'd8;
            3'd5:    return 4'd9;
            3'd6:    return 4'd13;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] clr_reg(input logic [2:0] b);
        case (b)
            3'd0:    return 4'd2;
            3'd1:    return 4'd4;
            3'd2:    return 4'd6;
            3'd3:    return 4'd7;
            3'd4:    return 4'd8;
            3'd5:    return 4'd9;
            3'd6:    return 4'd13;
            default: return 4'd1;
        endcase
    endfunction

    always_comb begin
        bus = '0;
        case (read_en)
            5'd16:   bus = dm_rdata;
            5'd17:   bus = im_data;
            default: if (!read_en[4]) bus = regs_q[read_en[3:0]];
        endcase
    end

    // Later assignments override earlier ones: clear > write > increment.
    always_comb begin
        for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
        for (int b = 0; b < 7; b++)
            if (inc_en[b]) regs_d[inc_reg(3'(b))] = regs_q[inc_reg(3'(b))] + DATA_W'(1);
        for (int b = 0; b < 12; b++)
            if (write_en[b]) regs_d[wr_reg(4'(b))] = bus;
        if (write_en[13]) regs_d[R_AC] = aluq_q;
        for (int b = 0; b < 8; b++)
            if (rst_en[b]) regs_d[clr_reg(3'(b))] = '0;
        regs_d[0] = '0;
    end

    always_comb begin
        aluq_d = aluq_q;
        case (alu_op)
            3'd1: aluq_d = regs_q[R_AC] + regs_q[5];
            3'd2: aluq_d = regs_q[R_AC] - regs_q[5];
`ifdef CORE_DATAPATH_MUL_EN
            3'd3: aluq_d = regs_q[R_AC] * regs_q[5];
`else
            3'd3: aluq_d = '0;
`endif
            default: aluq_d = aluq_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            aluq_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            aluq_q <= aluq_d;
        end
    end

    assign ins         = regs_q[R_IR];
    assign z           = aluq_q;
    assign im_addr     = regs_q[R_PC];
    assign dm_addr     = regs_q[R_DAR];
    assign dm_wdata    = bus;
    assign dm_we       = write_en[12] & ~rst;
    assign unused_bits = ^{write_en[15:14], inc_en[7]};
endmodule
